// File: rtl/calc_arbiter.sv
// calc_arbiter
//   Shares one Calc unit between two requesters. A round-robin pick in IDLE
//   latches the winner's op/operands. LAUNCH issues a single calc_go pulse.
//   WAIT then waits for calc_done, guarded by a watchdog. RESP returns the
//   result with a one-cycle ack to the owner.
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   req[1:0]            per-requester request, held until ack
//   op0/op1, a0/a1,     requester op codes and operands
//   b0/b1
//   gnt[1:0]            one-hot owner of the Calc, 0 when idle
//   ack[1:0]            one-cycle completion pulse to the owner
//   result[DW-1:0]      captured Calc output (0 on timeout), valid with ack
//   err                 transaction timed out, valid with ack
//   calc_go/op/in1/in2  launch strobe and latched operands to the Calc
//   calc_done/out       Calc completion and result
module calc_arbiter #(
   parameter int DW      = 4,
   parameter int TIMEOUT = 64,
   parameter int TW      = 7
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [1:0]    req,
   input  logic [1:0]    op0,
   input  logic [1:0]    op1,
   input  logic [DW-1:0] a0,
   input  logic [DW-1:0] a1,
   input  logic [DW-1:0] b0,
   input  logic [DW-1:0] b1,
   output logic [1:0]    gnt,
   output logic [1:0]    ack,
   output logic [DW-1:0] result,
   output logic          err,
   output logic          calc_go,
   output logic [1:0]    calc_op,
   output logic [DW-1:0] calc_in1,
   output logic [DW-1:0] calc_in2,
   input  logic          calc_done,
   input  logic [DW-1:0] calc_out
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } state_e;

   // Operand bundle latched at grant time.
   typedef struct packed {
      logic [1:0]    op;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
   } calc_req_t;

   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   state_e        state_q, state_d;
   logic [1:0]    gnt_q, gnt_d;
   logic          last_q, last_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [DW-1:0] result_q, result_d;
   logic          err_q, err_d;
   calc_req_t     cur_q, cur_d;

   calc_req_t     req0, req1;
   logic          sel;

   assign req0 = '{op: op0, a: a0, b: b0};
   assign req1 = '{op: op1, a: a1, b: b1};

   // Winner: the single requester if only one is asking, otherwise the one
   // that was not served last.
   always_comb begin
      sel = 1'b0;
      if (req == 2'b11) sel = ~last_q;
      else              sel = req[1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         gnt_q    <= '0;
         last_q   <= 1'b1;
         timer_q  <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
         cur_q    <= '0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         last_q   <= last_d;
         timer_q  <= timer_d;
         result_q <= result_d;
         err_q    <= err_d;
         cur_q    <= cur_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      last_d   = last_q;
      timer_d  = timer_q;
      result_d = result_q;
      err_d    = err_q;
      cur_d    = cur_q;
      unique case (state_q)
         IDLE: begin
            if (req != 2'b00) begin
               gnt_d   = sel ? 2'b10 : 2'b01;
               cur_d   = sel ? req1 : req0;
               state_d = LAUNCH;
            end
         end
         LAUNCH: begin
            timer_d = '0;
            state_d = WAIT;
         end
         WAIT: begin
            timer_d = timer_q + TW'(1);
            // done takes priority over the watchdog on the last cycle
            if (calc_done) begin
               result_d = calc_out;
               err_d    = 1'b0;
               state_d  = RESP;
            end else if (timer_q == TMO_LAST) begin
               result_d = '0;
               err_d    = 1'b1;
               state_d  = RESP;
            end
         end
         RESP: begin
            last_d  = gnt_q[1];
            gnt_d   = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign gnt      = gnt_q;
   assign ack      = (state_q == RESP) ? gnt_q : 2'b00;
   assign result   = result_q;
   assign err      = err_q;
   assign calc_go  = (state_q == LAUNCH);
   assign calc_op  = cur_q.op;
   assign calc_in1 = cur_q.a;
   assign calc_in2 = cur_q.b;

endmodule

// File: tb/tb_calc_arbiter.sv
module tb_calc_arbiter;
   localparam int DW = 4;

   logic          clk, rst_n;
   logic [1:0]    req, op0, op1;
   logic [DW-1:0] a0, a1, b0, b1;
   logic [1:0]    gnt, ack, calc_op;
   logic [DW-1:0] result, calc_in1, calc_in2, calc_out;
   logic          err, calc_go, calc_done;

   calc_arbiter #(.DW(DW), .TIMEOUT(8), .TW(4)) dut (
      .clk(clk), .rst_n(rst_n), .req(req),
      .op0(op0), .op1(op1), .a0(a0), .a1(a1), .b0(b0), .b1(b1),
      .gnt(gnt), .ack(ack), .result(result), .err(err),
      .calc_go(calc_go), .calc_op(calc_op), .calc_in1(calc_in1), .calc_in2(calc_in2),
      .calc_done(calc_done), .calc_out(calc_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]    ack;
      logic [DW-1:0] res;
      logic          err;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   m_delay = 0;   // model: done in the m_delay-th cycle after go, 0 = never
   int   m_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] calc_f(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
      case (op)
         2'b00:   calc_f = a + b;
         2'b01:   calc_f = a - b;
         2'b10:   calc_f = a & b;
         default: calc_f = a ^ b;
      endcase
   endfunction

   // Calc model: computes from the operands it sees at go.
   always @(posedge clk) begin
      if (!rst_n) begin
         m_cnt = 0;
         calc_done <= 1'b0;
      end else begin
         if (calc_go) begin
            m_cnt = m_delay;
            calc_out <= calc_f(calc_op, calc_in1, calc_in2);
         end else if (m_cnt > 0) begin
            m_cnt = m_cnt - 1;
         end
         calc_done <= (m_cnt == 1);
      end
   end

   // Scoreboard consumer and invariants.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("inv_onehot", 32'($onehot0(gnt)), 1);
         chk("inv_ack_sub", 32'(ack & ~gnt), 0);
         if (ack != 2'b00) begin
            if (sb.size() == 0) begin
               chk("unexp_ack", 32'(ack), 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("ack_owner", 32'(ack), 32'(e.ack));
               chk("result", 32'(result), 32'(e.res));
               chk("err", 32'(err), 32'(e.err));
            end
         end
      end
   end

   task automatic chk_zero(input string tag);
      chk({tag, "_gnt"}, 32'(gnt), 0);
      chk({tag, "_ack"}, 32'(ack), 0);
      chk({tag, "_res"}, 32'(result), 0);
      chk({tag, "_err"}, 32'(err), 0);
      chk({tag, "_go"}, 32'(calc_go), 0);
      chk({tag, "_op"}, 32'(calc_op), 0);
      chk({tag, "_in1"}, 32'(calc_in1), 0);
      chk({tag, "_in2"}, 32'(calc_in2), 0);
   endtask

   task automatic run_txn(input int r, input logic [1:0] op, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input int d, input logic terr, input bit perturb);
      exp_t e;
      int   gos = 0;
      bit   granted = 0;
      bit   seen = 0;
      e.ack = (r == 0) ? 2'b01 : 2'b10;
      e.res = terr ? '0 : calc_f(op, a, b);
      e.err = terr;
      sb.push_back(e);
      m_delay = d;
      if (r == 0) begin op0 = op; a0 = a; b0 = b; end
      else        begin op1 = op; a1 = a; b1 = b; end
      req = e.ack;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (calc_go) gos++;
         if (!granted && gnt != 2'b00) begin
            granted = 1;
            chk("gnt", 32'(gnt), 32'(e.ack));
            if (perturb) a0 = 4'd9;
         end
         if (ack != 2'b00) begin
            seen = 1;
            chk("calc_op", 32'(calc_op), 32'(op));
            chk("calc_in1", 32'(calc_in1), 32'(a));
            chk("calc_in2", 32'(calc_in2), 32'(b));
            chk("go_pulses", gos, 1);
            req = 2'b00;
            break;
         end
      end
      if (!seen) begin
         chk("ack_timeout", 0, 1);
         req = 2'b00;
      end
      @(negedge clk);
      chk("ack_one_cycle", 32'(ack), 0);
      chk("gnt_clear", 32'(gnt), 0);
   endtask

   initial begin
      int acks;
      clk = 0; rst_n = 0; req = '0;
      op0 = '0; op1 = '0; a0 = '0; a1 = '0; b0 = '0; b1 = '0;
      calc_out = '0;
      repeat (3) @(negedge clk);
      chk_zero("rst");
      rst_n = 1;
      @(negedge clk);

      run_txn(0, 2'b00, 4'd3, 4'd5, 4, 1'b0, 0);   // 8
      run_txn(0, 2'b00, 4'd3, 4'd5, 3, 1'b0, 1);   // a0 changed after grant
      run_txn(1, 2'b01, 4'd7, 4'd2, 0, 1'b1, 0);   // never done -> timeout
      run_txn(1, 2'b10, 4'hC, 4'hA, 2, 1'b0, 0);   // normal after timeout
      run_txn(0, 2'b00, 4'd2, 4'd4, 8, 1'b0, 0);   // done on final timeout cycle -> 6
      run_txn(1, 2'b11, 4'd5, 4'd3, 1, 1'b0, 0);   // minimum latency

      // Reset while in WAIT abandons the transaction.
      op0 = 2'b00; a0 = 4'd1; b0 = 4'd1; m_delay = 0; req = 2'b01;
      repeat (5) @(negedge clk);
      chk("abort_gnt", 32'(gnt), 1);
      rst_n = 0;
      #1;
      chk_zero("abort");
      req = 2'b00;
      repeat (2) @(negedge clk);
      chk("abort_noack", 32'(ack), 0);
      rst_n = 1;
      @(negedge clk);
      run_txn(1, 2'b00, 4'd6, 4'd7, 3, 1'b0, 0);   // 13

      // Round-robin with both requests held, fresh from reset.
      rst_n = 0;
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      op0 = 2'b00; a0 = 4'd1; b0 = 4'd2;
      op1 = 2'b11; a1 = 4'hF; b1 = 4'd5;
      m_delay = 2;
      for (int i = 0; i < 4; i++) begin
         exp_t e;
         e.ack = (i % 2 == 0) ? 2'b01 : 2'b10;
         e.res = (i % 2 == 0) ? 4'd3 : 4'hA;
         e.err = 1'b0;
         sb.push_back(e);
      end
      req = 2'b11;
      acks = 0;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (ack != 2'b00) acks++;
         if (acks == 4) break;
      end
      req = 2'b00;
      chk("rr_acks", acks, 4);
      repeat (4) @(negedge clk);
      chk("rr_idle_gnt", 32'(gnt), 0);
      chk("sb_empty", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
